xdma_read_data_mover: RTL and testbench
=======================================

XDMA_READ_DATA_MOVER -- requirements
Module: xdma_read_data_mover

Interface
REQ-001 SHALL have parameter DataWidth, default 512, AXI data width in bits (power of two, 64 or more).
REQ-002 SHALL have parameter AddrWidth, default 48, AXI address width in bits.
REQ-003 SHALL have parameter AxiIdWidth, default 4, AR ID width in bits.
REQ-004 SHALL have parameter ReqFifoDepth, default 4, number of bursts buffered or in flight.
REQ-005 SHALL have port clk_i, input, 1, clock; all logic on the rising edge.
REQ-006 SHALL have port rst_ni, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port rd_addr_i, input, AddrWidth, burst start address.
REQ-008 SHALL have port rd_len_i, input, 8, AXI len (beats minus 1).
REQ-009 SHALL have port rd_last_i, input, 1, burst is the final burst of a transfer.
REQ-010 SHALL have port rd_valid_i, input, 1, read request valid.
REQ-011 SHALL have port rd_ready_o, output, 1, read request ready.
REQ-012 SHALL have port ar_id_o, output, AxiIdWidth, AR ID, constant 0.
REQ-013 SHALL have port ar_addr_o, output, AddrWidth, AR address.
REQ-014 SHALL have port ar_len_o, output, 8, AR len.
REQ-015 SHALL have port ar_size_o, output, 3, AR size, constant log2(DataWidth/8).
REQ-016 SHALL have port ar_burst_o, output, 2, AR burst, constant INCR (2'b01).
REQ-017 SHALL have port ar_valid_o, output, 1, AR valid.
REQ-018 SHALL have port ar_ready_i, input, 1, AR ready.
REQ-019 SHALL have port r_data_i, input, DataWidth, R data.
REQ-020 SHALL have port r_resp_i, input, 2, R response.
REQ-021 SHALL have port r_last_i, input, 1, R last.
REQ-022 SHALL have port r_valid_i, input, 1, R valid.
REQ-023 SHALL have port r_ready_o, output, 1, R ready.
REQ-024 SHALL have port data_o, output, DataWidth, read data stream to the data path.
REQ-025 SHALL have port data_valid_o, output, 1, stream valid.
REQ-026 SHALL have port data_ready_i, input, 1, stream ready.
REQ-027 SHALL have port trans_complete_o, output, 1, one-cycle pulse when a transfer has been fully delivered.
REQ-028 SHALL have port error_o, output, 1, sticky error flag (bad response or RLAST mismatch).

Function
REQ-029 SHALL drive rd_ready_o = !ar_fifo_full && !rdesc_fifo_full; on acceptance push {addr,len} to the AR FIFO and {len,last} to the R-descriptor FIFO in the same cycle; both FIFOs are ReqFifoDepth deep and non-fall-through.
REQ-030 SHALL drive ar_valid_o = AR FIFO non-empty, no earlier than 1 cycle after request acceptance; pop on ar_valid_o && ar_ready_i; AR fields stay stable while ar_valid_o && !ar_ready_i.
REQ-031 SHALL keep an 8-bit beat counter, reset to 0, incremented on each R handshake; on the beat where counter == head len, pop the R-descriptor FIFO and clear the counter, so at most ReqFifoDepth bursts are ever outstanding.
REQ-032 SHALL drive r_ready_o = R-descriptor FIFO non-empty && output buffer not full; r_ready_o SHALL NOT depend combinationally on data_ready_i.
REQ-033 SHALL buffer R beats in a 2-entry skid buffer, each entry tagged with transfer-end (descriptor last && final beat); throughput 1 beat/cycle; data_o stable while data_valid_o && !data_ready_i; first-beat latency 1 cycle.
REQ-034 SHALL pulse trans_complete_o for exactly 1 cycle, in the cycle after a tagged beat handshakes on data_o; back-to-back transfers give separate pulses.
REQ-035 SHALL set error_o on an accepted beat with r_resp_i[1]==1, or with r_last_i != (counter == head len); error_o is cleared only by reset; data is forwarded unchanged and the counter follows the descriptor, not r_last_i.
REQ-036 SHALL treat rd_len_i == 0 as a single-beat burst, with descriptor pop and tagging on that beat.
REQ-037 SHALL accept simultaneous request push, AR pop, R-descriptor pop and stream handshake in one cycle without loss.

Reset
REQ-038 SHALL, on reset (asynchronous, including mid-burst): empty both FIFOs and the skid buffer, clear the counter, and drive rd_ready_o=1, ar_valid_o=0, r_ready_o=0, data_valid_o=0, trans_complete_o=0, error_o=0, data_o=0.

Structure
REQ-039 SHALL take the descriptor typedefs (ar_desc_t {addr,len}, r_desc_t {len,last}) and the AXI burst/resp constants from the shared xdma package; FIFOs SHALL be fifo_v3 instances.
REQ-040 SHALL put the 2-entry tagged skid buffer in one sub-module, xdma_read_skid_buffer.

Verification
REQ-041 Bench SHALL cover: request addr=0x1000, len=3, last=1, with AR and R always ready -> one AR (len=3, size=6 for 512b), 4 beats out, one trans_complete_o pulse after the 4th handshake.
REQ-042 Bench SHALL cover: 5 requests pushed with ar_ready_i=0 and depth 4 -> rd_ready_o low after the 4th acceptance; the 5th is accepted the cycle after the first AR handshake.
REQ-043 Bench SHALL cover: data_ready_i toggling at 50% during a len=7 burst -> all 8 beats in order, no duplicates, r_ready_o low while the buffer is full.
REQ-044 Bench SHALL cover: r_resp_i=2'b10 on beat 2 of 4 -> error_o rises the next cycle and stays high; all 4 beats are still delivered.
REQ-045 Bench SHALL cover: r_last_i asserted on beat 1 of len=2 -> error_o set; descriptor pops after beat 3.
REQ-046 Bench SHALL cover: reset asserted mid-burst, then a new len=0, last=1 request -> clean restart, 1 beat out, 1 trans_complete_o pulse.

Source files
------------

// File: rtl/xdma_pkg.sv
// rtl/xdma_pkg.sv - shared XDMA descriptor types and AXI constants
//
// Purpose: descriptor structs carried through the read data mover FIFOs,
// AXI burst/response encodings, and the AR size helper.
// Ports: none (package).
package xdma_pkg;

  // Descriptors hold the widest supported address; movers narrow it at the port.
  localparam int unsigned XdmaAddrWidth = 64;

  localparam logic [1:0] AxiBurstFixed = 2'b00;
  localparam logic [1:0] AxiBurstIncr  = 2'b01;
  localparam logic [1:0] AxiBurstWrap  = 2'b10;

  localparam logic [1:0] AxiRespOkay   = 2'b00;
  localparam logic [1:0] AxiRespExokay = 2'b01;
  localparam logic [1:0] AxiRespSlverr = 2'b10;
  localparam logic [1:0] AxiRespDecerr = 2'b11;

  typedef struct packed {
    logic [XdmaAddrWidth-1:0] addr;
    logic [7:0]               len;
  } ar_desc_t;

  typedef struct packed {
    logic [7:0] len;
    logic       last;
  } r_desc_t;

  // AXI AxSIZE for a full-width beat: log2 of the bytes per beat.
  function automatic logic [2:0] axi_size(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - synchronous non-fall-through FIFO
//
// Purpose: DEPTH-entry FIFO; data_o shows the head entry, a push is only
// visible at data_o from the cycle after it was written.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   full_o, empty_o occupancy flags
//   data_i, push_i  write side (push ignored when full)
//   data_o, pop_i   read side (pop ignored when empty)
module fifo_v3 #(
  parameter int unsigned DEPTH = 4,
  parameter type dtype = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  dtype             mem_q [DEPTH];
  dtype             mem_d [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d = (wr_ptr_q == AddrW'(DEPTH - 1)) ? '0 : wr_ptr_q + AddrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == AddrW'(DEPTH - 1)) ? '0 : rd_ptr_q + AddrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/xdma_read_skid_buffer.sv
// rtl/xdma_read_skid_buffer.sv - 2-entry tagged output buffer for R beats
//
// Purpose: decouples the R channel from the downstream stream so that
// r_ready never depends on the stream's ready; each beat carries a tag.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   in_data_i, in_tag_i        beat and its transfer-end tag
//   in_valid_i                 write strobe (caller guarantees !full_o)
//   full_o                     both entries occupied
//   out_data_o, out_tag_o      head beat and tag (zero while empty after reset)
//   out_valid_o, out_ready_i   stream handshake
module xdma_read_skid_buffer #(
  parameter int unsigned DataWidth = 512
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DataWidth-1:0] in_data_i,
  input  logic                 in_tag_i,
  input  logic                 in_valid_i,
  output logic                 full_o,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 out_tag_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i
);

  logic [DataWidth-1:0] data_q [2];
  logic [DataWidth-1:0] data_d [2];
  logic [1:0]           tag_q, tag_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;
  logic                 push, pop;

  assign full_o      = (count_q == 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = data_q[rd_ptr_q];
  assign out_tag_o   = tag_q[rd_ptr_q];
  assign push        = in_valid_i && !full_o;
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    data_d   = data_q;
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      data_d[wr_ptr_q] = in_data_i;
      tag_d[wr_ptr_q]  = in_tag_i;
      wr_ptr_d         = !wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = !rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q   <= '{default: '0};
      tag_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      data_q   <= data_d;
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/xdma_read_data_mover.sv
// rtl/xdma_read_data_mover.sv - issues AXI read bursts and streams the returned data
//
// Purpose: accepts burst requests, issues them on AR, counts R beats against
// the queued descriptors and forwards data through a 2-entry buffer, pulsing
// trans_complete_o after the final beat of a transfer leaves.
// Ports:
//   clk_i, rst_ni                          clock, asynchronous active-low reset
//   rd_addr_i/len_i/last_i/valid_i/ready_o burst request
//   ar_*                                   AXI read address channel
//   r_*                                    AXI read data channel
//   data_o/data_valid_o/data_ready_i       outgoing data stream
//   trans_complete_o                       one-cycle transfer-done pulse
//   error_o                                sticky bad-response / RLAST error
module xdma_read_data_mover
  import xdma_pkg::*;
#(
  parameter int unsigned DataWidth    = 512,
  parameter int unsigned AddrWidth    = 48,
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned ReqFifoDepth = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [AddrWidth-1:0]  rd_addr_i,
  input  logic [7:0]            rd_len_i,
  input  logic                  rd_last_i,
  input  logic                  rd_valid_i,
  output logic                  rd_ready_o,
  output logic [AxiIdWidth-1:0] ar_id_o,
  output logic [AddrWidth-1:0]  ar_addr_o,
  output logic [7:0]            ar_len_o,
  output logic [2:0]            ar_size_o,
  output logic [1:0]            ar_burst_o,
  output logic                  ar_valid_o,
  input  logic                  ar_ready_i,
  input  logic [DataWidth-1:0]  r_data_i,
  input  logic [1:0]            r_resp_i,
  input  logic                  r_last_i,
  input  logic                  r_valid_i,
  output logic                  r_ready_o,
  output logic [DataWidth-1:0]  data_o,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic                  trans_complete_o,
  output logic                  error_o
);

  localparam logic [2:0] ArSize = axi_size(DataWidth);

  ar_desc_t   ar_push, ar_head;
  r_desc_t    rdesc_push, rdesc_head;
  logic       ar_full, ar_empty, rdesc_full, rdesc_empty;
  logic       req_accept, ar_pop, r_hs, last_beat;
  logic       skid_full, out_tag, out_hs;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       error_q, error_d;
  logic       trans_complete_q, trans_complete_d;
  logic       unused_bits;

  // Request side: both descriptor queues are written together, so a request
  // is only taken when neither is full.
  assign rd_ready_o = !ar_full && !rdesc_full;
  assign req_accept = rd_valid_i && rd_ready_o;
  assign ar_push    = '{addr: XdmaAddrWidth'(rd_addr_i), len: rd_len_i};
  assign rdesc_push = '{len: rd_len_i, last: rd_last_i};

  fifo_v3 #(
    .DEPTH (ReqFifoDepth),
    .dtype (ar_desc_t)
  ) i_ar_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .full_o  (ar_full),
    .empty_o (ar_empty),
    .data_i  (ar_push),
    .push_i  (req_accept),
    .data_o  (ar_head),
    .pop_i   (ar_pop)
  );

  fifo_v3 #(
    .DEPTH (ReqFifoDepth),
    .dtype (r_desc_t)
  ) i_rdesc_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .full_o  (rdesc_full),
    .empty_o (rdesc_empty),
    .data_i  (rdesc_push),
    .push_i  (req_accept),
    .data_o  (rdesc_head),
    .pop_i   (r_hs && last_beat)
  );

  assign ar_id_o    = '0;
  assign ar_addr_o  = ar_head.addr[AddrWidth-1:0];
  assign ar_len_o   = ar_head.len;
  assign ar_size_o  = ArSize;
  assign ar_burst_o = AxiBurstIncr;
  assign ar_valid_o = !ar_empty;
  assign ar_pop     = ar_valid_o && ar_ready_i;

  // R side: beats are only taken while a descriptor is pending, which bounds
  // outstanding bursts by the descriptor queue depth.
  assign r_ready_o = !rdesc_empty && !skid_full;
  assign r_hs      = r_valid_i && r_ready_o;
  assign last_beat = (beat_cnt_q == rdesc_head.len);

  xdma_read_skid_buffer #(
    .DataWidth (DataWidth)
  ) i_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_data_i   (r_data_i),
    .in_tag_i    (rdesc_head.last && last_beat),
    .in_valid_i  (r_hs),
    .full_o      (skid_full),
    .out_data_o  (data_o),
    .out_tag_o   (out_tag),
    .out_valid_o (data_valid_o),
    .out_ready_i (data_ready_i)
  );

  assign out_hs = data_valid_o && data_ready_i;

  // Beat counting follows the descriptor length; r_last_i is only compared,
  // never used to terminate a burst.
  always_comb begin
    beat_cnt_d       = beat_cnt_q;
    error_d          = error_q;
    trans_complete_d = out_hs && out_tag;
    if (r_hs) begin
      beat_cnt_d = last_beat ? 8'd0 : beat_cnt_q + 8'd1;
      if (r_resp_i[1] || (r_last_i != last_beat)) begin
        error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_q       <= 8'd0;
      error_q          <= 1'b0;
      trans_complete_q <= 1'b0;
    end else begin
      beat_cnt_q       <= beat_cnt_d;
      error_q          <= error_d;
      trans_complete_q <= trans_complete_d;
    end
  end

  assign trans_complete_o = trans_complete_q;
  assign error_o          = error_q;

  // EXOKAY/OKAY are treated alike, and descriptor address bits above the
  // port width are always zero.
  assign unused_bits = ^{r_resp_i[0], ar_head.addr};

endmodule

// File: tb/tb_xdma_read_data_mover.sv
// tb/tb_xdma_read_data_mover.sv - self-checking bench for xdma_read_data_mover
module tb_xdma_read_data_mover;

  localparam int DW    = 512;
  localparam int AW    = 48;
  localparam int IW    = 4;
  localparam int DEPTH = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [AW-1:0] rd_addr_i = '0;
  logic [7:0]    rd_len_i = '0;
  logic          rd_last_i = 1'b0;
  logic          rd_valid_i = 1'b0;
  logic          rd_ready_o;
  logic [IW-1:0] ar_id_o;
  logic [AW-1:0] ar_addr_o;
  logic [7:0]    ar_len_o;
  logic [2:0]    ar_size_o;
  logic [1:0]    ar_burst_o;
  logic          ar_valid_o;
  logic          ar_ready_i = 1'b0;
  logic [DW-1:0] r_data_i = '0;
  logic [1:0]    r_resp_i = '0;
  logic          r_last_i = 1'b0;
  logic          r_valid_i = 1'b0;
  logic          r_ready_o;
  logic [DW-1:0] data_o;
  logic          data_valid_o;
  logic          data_ready_i = 1'b0;
  logic          trans_complete_o;
  logic          error_o;

  xdma_read_data_mover #(
    .DataWidth    (DW),
    .AddrWidth    (AW),
    .AxiIdWidth   (IW),
    .ReqFifoDepth (DEPTH)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .rd_addr_i        (rd_addr_i),
    .rd_len_i         (rd_len_i),
    .rd_last_i        (rd_last_i),
    .rd_valid_i       (rd_valid_i),
    .rd_ready_o       (rd_ready_o),
    .ar_id_o          (ar_id_o),
    .ar_addr_o        (ar_addr_o),
    .ar_len_o         (ar_len_o),
    .ar_size_o        (ar_size_o),
    .ar_burst_o       (ar_burst_o),
    .ar_valid_o       (ar_valid_o),
    .ar_ready_i       (ar_ready_i),
    .r_data_i         (r_data_i),
    .r_resp_i         (r_resp_i),
    .r_last_i         (r_last_i),
    .r_valid_i        (r_valid_i),
    .r_ready_o        (r_ready_o),
    .data_o           (data_o),
    .data_valid_o     (data_valid_o),
    .data_ready_i     (data_ready_i),
    .trans_complete_o (trans_complete_o),
    .error_o          (error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic          last;
  } req_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          tag;
  } beat_t;

  // Reference model: transactions waiting to be requested, waiting for AR,
  // waiting for R beats, and beats held inside the mover.
  req_t  req_q [$];
  req_t  arq [$];
  req_t  slq [$];
  beat_t dq [$];
  int    sl_beat;
  logic  r_pending;
  logic  exp_tc, exp_err;
  logic  sink_tog;

  int ar_pct, r_pct, sink_mode, inj_resp, inj_last;
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_ar, n_out, n_tc, n_acc, first_ar_cyc, acc5_cyc;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic push_req(input logic [AW-1:0] addr, input int len, input logic last);
    req_t r;
    r.addr = addr;
    r.len  = 8'(len);
    r.last = last;
    req_q.push_back(r);
  endtask

  // Asynchronous reset between clock edges, reset-state checks, model clear.
  task automatic do_reset();
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_rd_ready", rd_ready_o, 1);
    chk("rst_ar_valid", ar_valid_o, 0);
    chk("rst_r_ready", r_ready_o, 0);
    chk("rst_data_valid", data_valid_o, 0);
    chk("rst_trans_complete", trans_complete_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_data", data_o, 0);
    rd_valid_i = 0; ar_ready_i = 0; r_valid_i = 0; r_last_i = 0;
    r_resp_i = 0; r_data_i = '0; data_ready_i = 0;
    req_q.delete(); arq.delete(); slq.delete(); dq.delete();
    sl_beat = 0; r_pending = 0; exp_tc = 0; exp_err = 0; sink_tog = 0;
    ar_pct = 100; r_pct = 100; sink_mode = 0; inj_resp = -1; inj_last = -1;
    n_ar = 0; n_out = 0; n_tc = 0; n_acc = 0; first_ar_cyc = -1; acc5_cyc = -1;
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  // One clock cycle: check registered outputs against the model, drive the
  // request source / AXI slave / stream sink, update the model, advance.
  task automatic cycle();
    req_t  h;
    beat_t b;
    logic  fin, err_n, tc_n;
    int    desc;
    desc = arq.size() + slq.size();
    if (trans_complete_o === 1'b1) n_tc++;
    chk("rd_ready", rd_ready_o, (arq.size() < DEPTH) && (desc < DEPTH));
    chk("ar_valid", ar_valid_o, arq.size() > 0);
    chk("r_ready", r_ready_o, (desc > 0) && (dq.size() < 2));
    chk("data_valid", data_valid_o, dq.size() > 0);
    chk("trans_complete", trans_complete_o, exp_tc);
    chk("error", error_o, exp_err);

    rd_valid_i = (req_q.size() > 0);
    if (rd_valid_i) begin
      rd_addr_i = req_q[0].addr;
      rd_len_i  = req_q[0].len;
      rd_last_i = req_q[0].last;
    end

    ar_ready_i = ($urandom_range(99) < ar_pct);
    if (ar_valid_o && ar_ready_i && arq.size() > 0) begin
      h = arq.pop_front();
      chk("ar_addr", ar_addr_o, h.addr);
      chk("ar_len", ar_len_o, h.len);
      chk("ar_size", ar_size_o, 3'd6);
      chk("ar_burst", ar_burst_o, 2'b01);
      chk("ar_id", ar_id_o, 0);
      n_ar++;
      if (first_ar_cyc < 0) first_ar_cyc = cyc;
      slq.push_back(h);
    end

    if (!r_pending) begin
      if (slq.size() > 0 && $urandom_range(99) < r_pct) begin
        fin       = (sl_beat == int'(slq[0].len));
        r_valid_i = 1'b1;
        r_data_i  = rand_data();
        r_last_i  = fin ^ (sl_beat == inj_last);
        r_resp_i  = (sl_beat == inj_resp) ? 2'b10 : 2'b00;
      end else begin
        r_valid_i = 1'b0;
      end
    end

    sink_tog = !sink_tog;
    case (sink_mode)
      0:       data_ready_i = 1'b1;
      1:       data_ready_i = sink_tog;
      default: data_ready_i = ($urandom_range(1) == 1);
    endcase

    tc_n  = 1'b0;
    err_n = 1'b0;
    if (data_valid_o && data_ready_i && dq.size() > 0) begin
      b = dq.pop_front();
      chk("data_out", data_o, b.data);
      tc_n = b.tag;
      n_out++;
    end

    if (r_valid_i && r_ready_o && slq.size() > 0) begin
      fin = (sl_beat == int'(slq[0].len));
      b.data = r_data_i;
      b.tag  = fin && slq[0].last;
      dq.push_back(b);
      if (r_resp_i[1] || (r_last_i != fin)) err_n = 1'b1;
      if (fin) begin
        void'(slq.pop_front());
        sl_beat = 0;
      end else begin
        sl_beat++;
      end
      r_pending = 1'b0;
    end else begin
      r_pending = r_valid_i;
    end

    if (rd_valid_i && rd_ready_o) begin
      arq.push_back(req_q.pop_front());
      n_acc++;
      if (n_acc == 5) acc5_cyc = cyc;
    end

    @(posedge clk_i);
    #1;
    cyc++;
    exp_tc  = tc_n;
    exp_err = exp_err | err_n;
  endtask

  task automatic drain(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      if (req_q.size() == 0 && arq.size() == 0 && slq.size() == 0 && dq.size() == 0) done = 1'b1;
      else cycle();
    end
    chk("drain_done", done, 1);
    cycle();
    cycle();
  endtask

  initial begin
    // Single 4-beat transfer, everything ready.
    do_reset();
    push_req(48'h1000, 3, 1'b1);
    drain(200);
    chk("t1_ar_count", n_ar, 1);
    chk("t1_beats", n_out, 4);
    chk("t1_tc_pulses", n_tc, 1);

    // Five requests against a stalled AR channel.
    do_reset();
    ar_pct = 0;
    for (int i = 0; i < 5; i++) push_req(48'h2000 + 48'(i * 64), 0, 1'b1);
    for (int i = 0; i < 8; i++) cycle();
    chk("t2_accepted", n_acc, 4);
    chk("t2_rd_ready_low", rd_ready_o, 0);
    ar_pct = 100;
    drain(200);
    chk("t2_fifth_accept_lag", acc5_cyc - first_ar_cyc, 1);
    chk("t2_beats", n_out, 5);
    chk("t2_tc_pulses", n_tc, 5);

    // len=7 burst with a 50% toggling sink.
    do_reset();
    sink_mode = 1;
    push_req(48'h3000, 7, 1'b1);
    drain(200);
    chk("t3_beats", n_out, 8);
    chk("t3_tc_pulses", n_tc, 1);

    // SLVERR on the second beat of four.
    do_reset();
    inj_resp = 1;
    push_req(48'h4000, 3, 1'b1);
    drain(200);
    chk("t4_error_sticky", error_o, 1);
    chk("t4_beats", n_out, 4);

    // Early r_last on the first beat of a len=2 burst.
    do_reset();
    inj_last = 0;
    push_req(48'h5000, 2, 1'b1);
    drain(200);
    chk("t5_error", error_o, 1);
    chk("t5_beats", n_out, 3);

    // Random mix of bursts, throttled channels and sink.
    do_reset();
    ar_pct = 70; r_pct = 70; sink_mode = 2;
    for (int i = 0; i < 12; i++)
      push_req({16'h0, $urandom} & 48'hFFFF_FFFF_FFC0, $urandom_range(15), 1'($urandom_range(1)));
    drain(3000);
    chk("t6_error", error_o, 0);

    // Reset mid-burst, then a clean single-beat transfer.
    do_reset();
    sink_mode = 2;
    push_req(48'h6000, 15, 1'b1);
    for (int i = 0; i < 200 && n_out < 3; i++) cycle();
    chk("t7_mid_burst", (n_out >= 3) && (slq.size() > 0 || dq.size() > 0), 1);
    do_reset();
    push_req(48'h7000, 0, 1'b1);
    drain(200);
    chk("t7_beats", n_out, 1);
    chk("t7_tc_pulses", n_tc, 1);
    chk("t7_error", error_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
